mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide execution unit covering RV32M/RV64M-style ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the combinational integer ALU and is fed by a dedicated reservation-station entry.
- Result is broadcast once, tagged with its ROB tag, on the same result bus format the ALU uses; tag 0 means "no result".
- Accepts one operation at a time with a busy handshake, supports rollback, and freezes on rdy low.

Parameters:
XLEN, 32, operand/result width in bits (32 or 64)
TAG_W, 4, ROB tag width; tag value 0 reserved as "no result"
MUL_LAT, 3, cycles from accept edge to result for multiply ops (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
rdy  in  1  global enable; low freezes all state and outputs
in_rollback  in  1  misprediction flush; aborts any in-flight op
in_valid  in  1  issue strobe from reservation station
in_op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
in_value1  in  XLEN  rs1 operand
in_value2  in  XLEN  rs2 operand
in_rob_tag  in  TAG_W  destination ROB tag (non-zero)
out_busy  out  1  unit cannot accept an op this cycle
out_valid  out  1  one-cycle result strobe
out_value  out  XLEN  result
out_rob_tag  out  TAG_W  result tag; 0 whenever out_valid low

Behaviour:
- Reset (rst low at a clk edge): state IDLE. out_busy=0, out_valid=0, out_value=0, out_rob_tag=0. Iteration counter and operand registers are cleared. Reset overrides rollback, rdy and in_valid, and is effective mid-operation.
- rdy low: no register changes and outputs hold. A result strobe pending under rdy low remains asserted until the first rdy-high cycle, then lasts exactly one cycle.
- Accept: at an edge where rdy=1, in_valid=1, out_busy=0 and in_rollback=0.
  - in_valid while busy is ignored; the RS must not issue.
- FSM states:
  - IDLE -> MUL (multiply op) or DIV (divide op) on accept.
  - MUL -> DONE after MUL_LAT-1 further edges.
  - DIV -> DONE after XLEN iterations.
  - DONE -> IDLE, or directly to MUL/DIV on a same-cycle accept.
- out_busy: high in MUL and DIV, low in IDLE and DONE. Back-to-back issue is allowed in the result cycle.
- Latency, counted from the accept edge to the edge after which out_valid is high:
  - MUL_LAT for multiplies.
  - XLEN+1 for normal divides.
  - 1 for divide special cases.
- Multiply:
  - Forms the 2*XLEN product. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Signedness: MULH is signed*signed, MULHSU is signed rs1 * unsigned rs2, MULHU is unsigned*unsigned.
  - The product may be staged internally across MUL_LAT cycles.
- Divide: radix-2 restoring division on magnitudes, one quotient bit per cycle.
  - Signed ops negate the inputs up front.
  - Quotient sign is sign1 XOR sign2; remainder sign follows the dividend.
  - Sign fixup happens in the DONE transition.
- Divide special cases, resolved at accept with no iteration:
  - Divisor 0: quotient all ones; remainder = dividend (signed and unsigned).
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend, remainder = 0.
- Rollback: in_rollback=1 with rdy=1 forces IDLE at that edge.
  - An in-flight op is discarded and out_valid is low next cycle.
  - A result already on the bus in the rollback cycle is still visible that cycle (the ROB ignores it).
  - No accept happens in the rollback cycle.
- out_value and out_rob_tag are driven to 0 whenever out_valid is low.

Optional Feature:
MDU_DIV_EARLY_OUT_EN
- Defined: for unsigned-magnitude dividend < divisor, a divide finishes with latency 1: quotient 0, remainder = dividend, signs applied per the normal rules.
- Also defined: if both magnitudes fit in XLEN/2 bits, the iteration skips the upper half, giving latency XLEN/2+1.
- Undefined: all non-special divides take XLEN+1 cycles. Results are identical either way.

Test Plan:
- Reset mid-DIV (rst low for 1 cycle at iteration 10) -> next cycle out_busy=0, out_valid=0, out_rob_tag=0; a new MUL 6*7 tag 2 returns 42 after 3 cycles.
- MULH 0x80000000 * 0x80000000 tag 3 -> out_value 0x40000000 after 3 cycles; MULHSU 0xFFFFFFFF * 0x00000002 -> 0xFFFFFFFF; MULHU same operands -> 0x00000001.
- DIV -7 / 2 tag 5 -> 0xFFFFFFFD after 33 cycles; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in 1 cycle; REM 5 / 0 -> 5 in 1 cycle; DIVU 5 / 0 -> 0xFFFFFFFF.
- DIV 1000 / 3 issued, in_rollback at cycle 12 -> no out_valid ever for that tag; out_busy low the following cycle.
- MUL result cycle with in_valid=1 carrying DIVU 9 / 3 tag 7 -> accepted the same cycle; rdy held low 5 cycles during the DIV -> result 3 arrives exactly 5 cycles later than nominal, strobe one cycle wide.

Source files
------------

// File: rtl/mdu_unit_if.sv
// ---------------------------------------------------------------------------
// mdu_unit_if
//   Issue/result bundle between a reservation-station entry (master) and the
//   multiply/divide unit (slave).
//
//   in_valid     issue strobe
//   in_op        funct3: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   in_value1/2  rs1 / rs2 operands
//   in_rob_tag   destination ROB tag (non-zero)
//   out_busy     unit cannot accept an op this cycle
//   out_valid    one-cycle result strobe
//   out_value    result, zero while out_valid is low
//   out_rob_tag  result tag, zero while out_valid is low
// ---------------------------------------------------------------------------
interface mdu_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_value1;
  logic [XLEN-1:0]  in_value2;
  logic [TAG_W-1:0] in_rob_tag;
  logic             out_busy;
  logic             out_valid;
  logic [XLEN-1:0]  out_value;
  logic [TAG_W-1:0] out_rob_tag;

  modport master (
    output in_valid, in_op, in_value1, in_value2, in_rob_tag,
    input  out_busy, out_valid, out_value, out_rob_tag
  );

  modport slave (
    input  in_valid, in_op, in_value1, in_value2, in_rob_tag,
    output out_busy, out_valid, out_value, out_rob_tag
  );
endinterface

// File: rtl/mdu_unit.sv
// ---------------------------------------------------------------------------
// mdu_unit
//   Multi-cycle RV32M/RV64M multiply/divide unit. One op in flight; the result
//   is broadcast for one cycle with its ROB tag (tag 0 = no result).
//   Multiplies complete MUL_LAT edges after accept (accept edge counts as 1),
//   divides use radix-2 restoring iteration on magnitudes (XLEN+1 edges),
//   divide-by-zero and signed overflow resolve at accept (1 edge).
//
//   Ports
//     clk          clock
//     rst          synchronous active-low reset
//     rdy          global enable; low freezes all state and outputs
//     in_rollback  flush; returns to IDLE and blocks accept that edge
//     bus          mdu_unit_if.slave issue/result bundle
//
//   Build option
//     MDU_DIV_EARLY_OUT_EN  when defined, dividend magnitude < divisor
//                           magnitude finishes at accept, and operands whose
//                           magnitudes fit in XLEN/2 bits iterate only XLEN/2
//                           times. Results are unchanged.
// ---------------------------------------------------------------------------
module mdu_unit #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     in_rollback,
  mdu_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q, state_d, start_state;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvsr_q, result_q;
  logic             neg_quo_q, neg_rem_q, want_rem_q;
  logic [TAG_W-1:0] tag_q;

  logic busy, done, accept, last_step;
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign done      = (state_q == S_DONE);
  assign accept    = rdy && !in_rollback && bus.in_valid && !busy;
  assign last_step = (cnt_q == CNT_W'(1));

  // ---------------- operand decode ----------------
  logic [XLEN-1:0] v1, v2;
  logic            is_div, want_rem, div_signed;
  assign v1         = bus.in_value1;
  assign v2         = bus.in_value2;
  assign is_div     = bus.in_op[2];
  assign want_rem   = bus.in_op[1];
  assign div_signed = !bus.in_op[0];

  // ---------------- multiply (single product, latency padded by counter) ----
  // Operands are extended to 2*XLEN so one unsigned multiply covers all
  // signedness combinations modulo 2^(2*XLEN).
  logic              mul_a_signed, mul_b_signed;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
  logic [XLEN-1:0]   mul_result;
  assign mul_a_signed = bus.in_op[1] ^ bus.in_op[0];      // MULH, MULHSU
  assign mul_b_signed = (bus.in_op[1:0] == 2'b01);        // MULH
  assign mul_a        = {{XLEN{mul_a_signed & v1[XLEN-1]}}, v1};
  assign mul_b        = {{XLEN{mul_b_signed & v2[XLEN-1]}}, v2};
  assign mul_prod     = mul_a * mul_b;
  assign mul_result   = (bus.in_op[1:0] == 2'b00) ? mul_prod[XLEN-1:0]
                                                  : mul_prod[2*XLEN-1:XLEN];

  // ---------------- divide setup ----------------
  logic            sign1, sign2;
  logic [XLEN-1:0] mag1, mag2, quick_result;
  logic            div_zero, div_ovf, div_early, div_half, div_quick;
  assign sign1    = div_signed & v1[XLEN-1];
  assign sign2    = div_signed & v2[XLEN-1];
  assign mag1     = sign1 ? -v1 : v1;
  assign mag2     = sign2 ? -v2 : v2;
  assign div_zero = (v2 == '0);
  assign div_ovf  = div_signed && (v1 == MOST_NEG) && (v2 == '1);

`ifdef MDU_DIV_EARLY_OUT_EN
  assign div_early = (mag1 < mag2);
  assign div_half  = (mag1[XLEN-1:XLEN/2] == '0) && (mag2[XLEN-1:XLEN/2] == '0);
`else
  assign div_early = 1'b0;
  assign div_half  = 1'b0;
`endif

  assign div_quick = div_zero || div_ovf || div_early;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    quick_result = want_rem ? v1 : '0;   // early-out: q = 0, r = dividend
    if (div_zero)     quick_result = want_rem ? v1 : '1;
    else if (div_ovf) quick_result = want_rem ? '0 : v1;
  end

  // ---------------- one restoring-division step ----------------
  logic [XLEN:0]   rem_shift, trial;
  logic            trial_ok;
  logic [XLEN-1:0] rem_next, quo_next, quo_fix, rem_fix, div_result;
  always_comb begin
    rem_shift  = {rem_q, quo_q[XLEN-1]};
    trial      = rem_shift - {1'b0, dvsr_q};
    trial_ok   = !trial[XLEN];
    rem_next   = trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_next   = {quo_q[XLEN-2:0], trial_ok};
    quo_fix    = neg_quo_q ? -quo_next : quo_next;
    rem_fix    = neg_rem_q ? -rem_next : rem_next;
    div_result = want_rem_q ? rem_fix : quo_fix;
  end

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    if (!is_div) start_state = (MUL_LAT == 1) ? S_DONE : S_MUL;
    else         start_state = div_quick ? S_DONE : S_DIV;
  end

  always_comb begin
    state_d = state_q;
    if (rdy) begin
      if (in_rollback) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: state_d = bus.in_valid ? start_state : S_IDLE;
          S_MUL, S_DIV:   if (last_step) state_d = S_DONE;
          default:        state_d = S_IDLE;
        endcase
      end
    end
  end

  // ---------------- datapath registers ----------------
  // NOTE: these are plain registers, not a memory array, so they take the
  // synchronous reset along with the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      want_rem_q <= 1'b0;
      tag_q      <= '0;
    end else if (accept) begin
      tag_q <= bus.in_rob_tag;
      if (!is_div) begin
        result_q <= mul_result;
        cnt_q    <= CNT_W'(MUL_LAT - 1);
      end else if (div_quick) begin
        result_q <= quick_result;
      end else begin
        rem_q      <= '0;
        quo_q      <= div_half ? (mag1 << (XLEN/2)) : mag1;
        dvsr_q     <= mag2;
        neg_quo_q  <= sign1 ^ sign2;
        neg_rem_q  <= sign1;
        want_rem_q <= want_rem;
        cnt_q      <= div_half ? CNT_W'(XLEN/2) : CNT_W'(XLEN);
      end
    end else if (rdy && !in_rollback && busy) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (state_q == S_DIV) begin
        rem_q <= rem_next;
        quo_q <= quo_next;
        // Sign fixup lands with the final quotient bit.
        if (last_step) result_q <= div_result;
      end
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.out_busy    = busy;
    bus.out_valid   = done;
    bus.out_value   = done ? result_q : '0;
    bus.out_rob_tag = done ? tag_q : '0;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// ---------------------------------------------------------------------------
// tb_mdu_unit
//   Self-checking bench for mdu_unit (XLEN=32, TAG_W=4, MUL_LAT=3). Expected
//   results come from plain integer arithmetic on the RV32M rules; expected
//   latencies come from the op class. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mdu_unit;
  localparam int XLEN    = 32;
  localparam int TAG_W   = 4;
  localparam int MUL_LAT = 3;
  localparam int TIMEOUT = 200;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic in_rollback;
  int   total = 0;
  int   bad   = 0;

  mdu_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mdu_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .in_rollback (in_rollback),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = signed'(a);
    ib  = signed'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    ref_result = '0;
    case (op)
      OP_MUL:    begin p = sa * sb; ref_result = p[31:0];  end
      OP_MULH:   begin p = sa * sb; ref_result = p[63:32]; end
      OP_MULHSU: begin p = sa * ub; ref_result = p[63:32]; end
      OP_MULHU:  begin p = ua * ub; ref_result = p[63:32]; end
      OP_DIV:    ref_result = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      OP_REM:    ref_result = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      OP_DIVU:   ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:   ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    logic is_signed;
    logic [31:0] ma, mb;
    is_signed = op[2] && !op[0];
    ma = (is_signed && a[31]) ? -a : a;
    mb = (is_signed && b[31]) ? -b : b;
    if (!op[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
    if (ma < 32'h0001_0000 && mb < 32'h0001_0000) return XLEN/2 + 1;
`endif
    return XLEN + 1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_value1  = a;
    bus.in_value2  = b;
    bus.in_rob_tag = tag;
  endtask

  // Issues one op and waits for its strobe; lat counts edges from the accept
  // edge (edge 1) to the edge after which out_valid is seen, -1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag,
                        output logic [31:0] val, output logic [3:0] rtag,
                        output int lat);
    val = '0; rtag = '0; lat = -1;
    @(negedge clk);
    drive_op(op, a, b, tag);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin
        val = bus.out_value; rtag = bus.out_rob_tag; lat = k;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v; logic [3:0] t; int lat;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.out_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.out_busy); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_value !== 32'd0) begin bad++; $display("FAIL reset_value: got %h want 0", bus.out_value); end
    total++; if (bus.out_rob_tag !== 4'd0) begin bad++; $display("FAIL reset_tag: got %h want 0", bus.out_rob_tag); end
    rst = 1'b1;

    // Reset in the middle of a divide.
    @(negedge clk);
    drive_op(OP_DIV, 32'd1000, 32'd7, 4'd6);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total++; if (bus.out_busy !== 1'b0) begin bad++; $display("FAIL middiv_reset_busy: got %b want 0", bus.out_busy); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL middiv_reset_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_rob_tag !== 4'd0) begin bad++; $display("FAIL middiv_reset_tag: got %h want 0", bus.out_rob_tag); end

    run_op(OP_MUL, 32'd6, 32'd7, 4'd2, v, t, lat);
    total++; if (v !== 32'd42) begin bad++; $display("FAIL mul_after_reset_value: got %h want 2a", v); end
    total++; if (t !== 4'd2) begin bad++; $display("FAIL mul_after_reset_tag: got %h want 2", t); end
    total++; if (lat != 3) begin bad++; $display("FAIL mul_after_reset_latency: got %0d want 3", lat); end
  endtask

  task automatic test_mul();
    logic [31:0] v; logic [3:0] t; int lat;
    run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, 4'd3, v, t, lat);
    total++; if (v !== 32'h4000_0000) begin bad++; $display("FAIL mulh_value: got %h want 40000000", v); end
    total++; if (t !== 4'd3) begin bad++; $display("FAIL mulh_tag: got %h want 3", t); end
    total++; if (lat != 3) begin bad++; $display("FAIL mulh_latency: got %0d want 3", lat); end
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 4'd4, v, t, lat);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulhsu_value: got %h want ffffffff", v); end
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 4'd5, v, t, lat);
    total++; if (v !== 32'h0000_0001) begin bad++; $display("FAIL mulhu_value: got %h want 00000001", v); end
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 4'd6, v, t, lat);
    total++; if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_low_value: got %h want fffffffe", v); end
  endtask

  task automatic test_div();
    logic [31:0] v; logic [3:0] t; int lat;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'd5, v, t, lat);
    total++; if (v !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_value: got %h want fffffffd", v); end
    total++; if (t !== 4'd5) begin bad++; $display("FAIL div_neg_tag: got %h want 5", t); end
    total++; if (lat != ref_latency(OP_DIV, 32'hFFFF_FFF9, 32'd2)) begin bad++; $display("FAIL div_neg_latency: got %0d want %0d", lat, ref_latency(OP_DIV, 32'hFFFF_FFF9, 32'd2)); end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 4'd5, v, t, lat);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_neg_value: got %h want ffffffff", v); end
    run_op(OP_DIVU, 32'd100, 32'd7, 4'd1, v, t, lat);
    total++; if (v !== 32'd14) begin bad++; $display("FAIL divu_value: got %h want 0000000e", v); end
    run_op(OP_REMU, 32'd100, 32'd7, 4'd1, v, t, lat);
    total++; if (v !== 32'd2) begin bad++; $display("FAIL remu_value: got %h want 00000002", v); end
  endtask

  task automatic test_special();
    logic [31:0] v; logic [3:0] t; int lat;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, v, t, lat);
    total++; if (v !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_value: got %h want 80000000", v); end
    total++; if (lat != 1) begin bad++; $display("FAIL div_ovf_latency: got %0d want 1", lat); end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, v, t, lat);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL rem_ovf_value: got %h want 0", v); end
    run_op(OP_REM, 32'd5, 32'd0, 4'd10, v, t, lat);
    total++; if (v !== 32'd5) begin bad++; $display("FAIL rem_by_zero_value: got %h want 5", v); end
    total++; if (lat != 1) begin bad++; $display("FAIL rem_by_zero_latency: got %0d want 1", lat); end
    run_op(OP_DIVU, 32'd5, 32'd0, 4'd11, v, t, lat);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_by_zero_value: got %h want ffffffff", v); end
  endtask

  task automatic test_rollback();
    int seen;
    @(negedge clk);
    drive_op(OP_DIV, 32'd1000, 32'd3, 4'd9);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    in_rollback = 1'b1;
    @(negedge clk);
    in_rollback = 1'b0;
    total++; if (bus.out_busy !== 1'b0) begin bad++; $display("FAIL rollback_busy: got %b want 0", bus.out_busy); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rollback_valid: got %b want 0", bus.out_valid); end
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rollback_no_result: got %0d strobes want 0", seen); end

    // An issue presented in the rollback cycle must not be accepted.
    drive_op(OP_MUL, 32'd2, 32'd3, 4'd12);
    in_rollback = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    in_rollback  = 1'b0;
    total++; if (bus.out_busy !== 1'b0) begin bad++; $display("FAIL rollback_no_accept: got busy %b want 0", bus.out_busy); end
  endtask

  task automatic test_back_to_back();
    int lat, exp_lat, width_ok;
    logic got_result;
    @(negedge clk);
    drive_op(OP_MUL, 32'd11, 32'd13, 4'd4);
    got_result = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin got_result = 1'b1; break; end
    end
    total++; if (!got_result || bus.out_value !== 32'd143) begin bad++; $display("FAIL b2b_mul_value: got %h want 0000008f", bus.out_value); end
    total++; if (bus.out_busy !== 1'b0) begin bad++; $display("FAIL b2b_result_cycle_busy: got %b want 0", bus.out_busy); end

    // Issue in the result cycle, then freeze for 5 edges mid-divide.
    drive_op(OP_DIVU, 32'd9, 32'd3, 4'd7);
    exp_lat = ref_latency(OP_DIVU, 32'd9, 32'd3) + 5;
    lat = -1;
    width_ok = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (k == 1) begin
        total++; if (bus.out_busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy: got %b want 1", bus.out_busy); end
      end
      if (k == 7) begin
        total++; if (bus.out_busy !== 1'b1) begin bad++; $display("FAIL b2b_frozen_busy: got %b want 1", bus.out_busy); end
      end
      if (bus.out_valid === 1'b1) begin
        lat = k;
        total++; if (bus.out_value !== 32'd3 || bus.out_rob_tag !== 4'd7) begin bad++; $display("FAIL b2b_div_result: got %h/%h want 00000003/7", bus.out_value, bus.out_rob_tag); end
        @(negedge clk);
        width_ok = (bus.out_valid === 1'b0) ? 1 : 0;
        break;
      end
      if (k == 4) rdy = 1'b0;
      if (k == 9) rdy = 1'b1;
    end
    rdy = 1'b1;
    total++; if (lat != exp_lat) begin bad++; $display("FAIL b2b_div_latency: got %0d want %0d", lat, exp_lat); end
    total++; if (width_ok != 1) begin bad++; $display("FAIL b2b_strobe_width: got %0d want 1", width_ok); end
  endtask

  task automatic test_rdy_hold();
    logic got_result;
    @(negedge clk);
    drive_op(OP_MUL, 32'd3, 32'd5, 4'd8);
    got_result = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin got_result = 1'b1; break; end
    end
    total++; if (!got_result) begin bad++; $display("FAIL hold_first_strobe: got none want 1"); end
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1 || bus.out_value !== 32'd15 || bus.out_rob_tag !== 4'd8) begin bad++; $display("FAIL hold_pending_strobe: got %b/%h/%h want 1/0000000f/8", bus.out_valid, bus.out_value, bus.out_rob_tag); end
    end
    rdy = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.out_value !== 32'd0) begin bad++; $display("FAIL hold_release: got %b/%h want 0/0", bus.out_valid, bus.out_value); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, v, exp_v;
    logic [2:0]  op;
    logic [3:0]  tag, t;
    int lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      tag = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 4))
        0: begin a = $urandom(); b = $urandom(); end
        1: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
        2: begin a = $urandom(); b = 32'd0; end
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: begin a = $urandom_range(0, 1000); b = $urandom() | 32'h0010_0000; end
      endcase
      exp_v   = ref_result(op, a, b);
      exp_lat = ref_latency(op, a, b);
      run_op(op, a, b, tag, v, t, lat);
      total++; if (v !== exp_v) begin bad++; $display("FAIL rand_value op=%0d a=%h b=%h: got %h want %h", op, a, b, v, exp_v); end
      total++; if (t !== tag) begin bad++; $display("FAIL rand_tag op=%0d: got %h want %h", op, t, tag); end
      total++; if (lat != exp_lat) begin bad++; $display("FAIL rand_latency op=%0d a=%h b=%h: got %0d want %0d", op, a, b, lat, exp_lat); end
    end
  endtask

  initial begin
    rst            = 1'b0;
    rdy            = 1'b1;
    in_rollback    = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_value1  = '0;
    bus.in_value2  = '0;
    bus.in_rob_tag = '0;

    test_reset();
    test_mul();
    test_div();
    test_special();
    test_rollback();
    test_back_to_back();
    test_rdy_hold();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
